// File: rtl/gen_timer_pkg.sv
// Shared constants for the multi-channel tick timer: mode encodings and
// default parameter values.
package gen_timer_pkg;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  localparam int DEF_PRESCALE   = 100;
  localparam int DEF_NCH        = 4;
  localparam int DEF_CNT_W      = 16;
  localparam int DEF_PERIOD_RST = 1;

endpackage

// File: rtl/gen_tick_prescaler.sv
// Shared base-tick prescaler: counts 0..PRESCALE-1 while any channel runs,
// sits at 0 otherwise, and flags the last count as base_tick.
module gen_tick_prescaler
  import gen_timer_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic clk,
  input  logic reset_n,
  input  logic active,
  output logic base_tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pcnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt <= '0;
    end else if (!active || pcnt == LAST) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

  assign base_tick = active && (pcnt == LAST);

endmodule

// File: rtl/gen_tick_timer.sv
// Multi-channel periodic/one-shot tick timer on a shared prescaler.
// Define GEN_TIMER_IRQ_EN to add sticky per-channel interrupt pending bits.
module gen_tick_timer
  import gen_timer_pkg::*;
#(
  parameter int PRESCALE   = DEF_PRESCALE,
  parameter int NCH        = DEF_NCH,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int PERIOD_RST = DEF_PERIOD_RST
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 cfg_we,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]                     cfg_period,
  input  logic                                 cfg_mode,
  input  logic [NCH-1:0]                       start,
  input  logic [NCH-1:0]                       stop,
  output logic [NCH-1:0]                       tick,
  output logic [NCH-1:0]                       busy
`ifdef GEN_TIMER_IRQ_EN
  ,
  input  logic [NCH-1:0]                       irq_clr,
  output logic                                 irq
`endif
);

  logic [NCH-1:0] run;
  logic [NCH-1:0] tick_bits;
  logic [NCH-1:0] wr_hit;
  logic           wr_ok;
  logic           active;
  logic           base_tick;

  assign active = |run;

  gen_tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk      (clk),
    .reset_n  (reset_n),
    .active   (active),
    .base_tick(base_tick)
  );

  // Out-of-range channel numbers are dropped here, before the per-channel decode.
  assign wr_ok = cfg_we && (int'(cfg_ch) < NCH);

  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < NCH; i++) begin
      wr_hit[i] = wr_ok && (int'(cfg_ch) == i);
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [CNT_W-1:0] period_q;
    logic             mode_q;
    logic [CNT_W-1:0] cnt_q;
    logic             run_q;
    logic             tick_q;
    logic [CNT_W-1:0] new_period;

    // Write-first: a start in the same cycle as a write sees the new period.
    assign new_period = wr_hit[g] ? cfg_period : period_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        period_q <= CNT_W'(PERIOD_RST);
        mode_q   <= MODE_PERIODIC;
      end else if (wr_hit[g]) begin
        period_q <= cfg_period;
        mode_q   <= cfg_mode;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        run_q  <= 1'b0;
        cnt_q  <= '0;
        tick_q <= 1'b0;
      end else begin
        tick_q <= 1'b0;
        if (stop[g]) begin
          run_q <= 1'b0;
        end else if (start[g] && new_period != '0) begin
          run_q <= 1'b1;
          cnt_q <= new_period - CNT_W'(1);
        end else if (run_q && base_tick) begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            tick_q <= 1'b1;
            if (mode_q == MODE_ONESHOT) begin
              run_q <= 1'b0;
              cnt_q <= '0;
            end else begin
              cnt_q <= period_q - CNT_W'(1);
            end
          end
        end
      end
    end

    assign run[g]       = run_q;
    assign tick_bits[g] = tick_q;
  end

  assign busy = run;
  assign tick = tick_bits;

`ifdef GEN_TIMER_IRQ_EN
  logic [NCH-1:0] irq_pend;

  // A new tick outranks a clear arriving in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_pend <= '0;
    end else begin
      irq_pend <= (irq_pend & ~irq_clr) | tick_bits;
    end
  end

  assign irq = |irq_pend;
`endif

endmodule

// File: tb/tb_gen_tick_timer.sv
// Directed bench for gen_tick_timer: a PRESCALE=4/NCH=2 instance for the main
// scenarios and a PRESCALE=1/NCH=3 instance for the out-of-range channel write.
module tb_gen_tick_timer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cfg_we;
  logic [0:0] cfg_ch;
  logic [7:0] cfg_period;
  logic       cfg_mode;
  logic [1:0] start;
  logic [1:0] stop;
  logic [1:0] tick;
  logic [1:0] busy;

  logic       cfg2_we;
  logic [1:0] cfg2_ch;
  logic [7:0] cfg2_period;
  logic       cfg2_mode;
  logic [2:0] start2;
  logic [2:0] stop2;
  logic [2:0] tick2;
  logic [2:0] busy2;

`ifdef GEN_TIMER_IRQ_EN
  logic [1:0] irq_clr;
  logic       irq;
  logic [2:0] irq2_clr;
  logic       irq2;
`endif

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  gen_tick_timer #(.PRESCALE(4), .NCH(2), .CNT_W(8), .PERIOD_RST(1)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_period(cfg_period),
    .cfg_mode  (cfg_mode),
    .start     (start),
    .stop      (stop),
    .tick      (tick),
    .busy      (busy)
`ifdef GEN_TIMER_IRQ_EN
    ,
    .irq_clr   (irq_clr),
    .irq       (irq)
`endif
  );

  gen_tick_timer #(.PRESCALE(1), .NCH(3), .CNT_W(8), .PERIOD_RST(1)) dut2 (
    .clk       (clk),
    .reset_n   (reset_n),
    .cfg_we    (cfg2_we),
    .cfg_ch    (cfg2_ch),
    .cfg_period(cfg2_period),
    .cfg_mode  (cfg2_mode),
    .start     (start2),
    .stop      (stop2),
    .tick      (tick2),
    .busy      (busy2)
`ifdef GEN_TIMER_IRQ_EN
    ,
    .irq_clr   (irq2_clr),
    .irq       (irq2)
`endif
  );

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // driver tasks: inputs change 1ns after the edge, outputs sampled there too
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic ch, input logic [7:0] period, input logic mode);
    cfg_we = 1'b1; cfg_ch = ch; cfg_period = period; cfg_mode = mode;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start(input logic [1:0] mask);
    start = mask;
    step();
    start = '0;
  endtask

  task automatic pulse_stop(input logic [1:0] mask);
    stop = mask;
    step();
    stop = '0;
  endtask

  task automatic measure(input int ch, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!tick[ch] && n < 100);
  endtask

  task automatic count_ticks(input int ch, input int cycles, output int c);
    c = 0;
    for (int k = 0; k < cycles; k++) begin
      step();
      if (tick[ch]) c++;
    end
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0; cfg_mode = 1'b0;
    start = '0; stop = '0;
    cfg2_we = 1'b0; cfg2_ch = '0; cfg2_period = '0; cfg2_mode = 1'b0;
    start2 = '0; stop2 = '0;
`ifdef GEN_TIMER_IRQ_EN
    irq_clr = '0; irq2_clr = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_tick", tick, 0);
    reset_n = 1'b1;
    step();

    // periodic: period 3 at prescale 4 -> 12-cycle gaps
    cfg_write(1'b0, 8'd3, 1'b0);
    pulse_start(2'b01);
    check("per_busy_rise", busy[0], 1);
    exp_q.push_back(12);
    exp_q.push_back(12);
    exp_q.push_back(12);
    while (exp_q.size() > 0) begin
      measure(0, n);
      check("per_gap", n, exp_q.pop_front());
      check("per_busy", busy[0], 1);
    end
    pulse_stop(2'b01);
    check("per_stopped", busy, 0);

    // one-shot: period 2 -> single tick after 8 cycles
    cfg_write(1'b1, 8'd2, 1'b1);
    pulse_start(2'b10);
    check("os_busy_rise", busy[1], 1);
    measure(1, n);
    check("os_first", n, 8);
    check("os_busy_fall", busy[1], 0);
    count_ticks(1, 30, n);
    check("os_no_more", n, 0);
    check("os_idle", busy, 0);

    // stop sampled on the expiry edge suppresses the tick
    pulse_start(2'b01);
    repeat (11) step();
    stop = 2'b01;
    step();
    stop = '0;
    check("stopx_tick", tick[0], 0);
    check("stopx_busy", busy[0], 0);
    count_ticks(0, 20, n);
    check("stopx_quiet", n, 0);
    pulse_start(2'b01);
    measure(0, n);
    check("stopx_restart", n, 12);
    pulse_stop(2'b01);

    // start with zero period is ignored
    cfg_write(1'b1, 8'd0, 1'b1);
    pulse_start(2'b10);
    check("zero_period_busy", busy, 0);

    // write-first: period 5 written with the start -> 20 cycles
    cfg_we = 1'b1; cfg_ch = 1'b0; cfg_period = 8'd5; cfg_mode = 1'b0;
    start = 2'b01;
    step();
    cfg_we = 1'b0; start = '0;
    check("wf_busy", busy[0], 1);
    measure(0, n);
    check("wf_first", n, 20);
    pulse_stop(2'b01);

    // reset mid-interval
    pulse_start(2'b01);
    repeat (7) step();
    reset_n = 1'b0;
    #1;
    check("mrst_busy", busy, 0);
    check("mrst_tick", tick, 0);
    step();
    reset_n = 1'b1;
    count_ticks(0, 30, n);
    check("mrst_no_tick", n, 0);
    check("mrst_idle", busy, 0);
    pulse_start(2'b01);
    measure(0, n);
    check("mrst_period_rst0", n, 4);
    measure(0, n);
    check("mrst_period_rst0_b", n, 4);
    pulse_stop(2'b01);
    pulse_start(2'b10);
    measure(1, n);
    check("mrst_mode_rst1", n, 4);
    measure(1, n);
    check("mrst_mode_rst1_b", n, 4);
    pulse_stop(2'b10);

    // out-of-range channel write on the 3-channel instance, prescale 1
    cfg2_we = 1'b1; cfg2_ch = 2'd3; cfg2_period = 8'd0; cfg2_mode = 1'b1;
    step();
    cfg2_we = 1'b0;
    start2 = 3'b111;
    step();
    start2 = '0;
    check("oor_busy", busy2, 3'b111);
    step();
    check("oor_tick1", tick2, 3'b111);
    step();
    check("oor_tick2", tick2, 3'b111);
    check("oor_busy2", busy2, 3'b111);
    stop2 = 3'b111;
    step();
    stop2 = '0;
    check("oor_stopped", busy2, 0);

`ifdef GEN_TIMER_IRQ_EN
    irq_clr = 2'b11;
    step();
    irq_clr = '0;
    check("irq_cleared", irq, 0);
    pulse_start(2'b01);
    measure(0, n);
    check("irq_tick_gap", n, 4);
    check("irq_pre", irq, 0);
    step();
    check("irq_set", irq, 1);
    measure(0, n);
    check("irq_tick_gap2", n, 3);
    irq_clr = 2'b01;
    step();
    irq_clr = '0;
    check("irq_set_wins", irq, 1);
    irq_clr = 2'b01;
    step();
    irq_clr = '0;
    check("irq_lone_clr", irq, 0);
    pulse_stop(2'b01);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
